// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: game states, tile codes,
// frog origin and score width used by the game sequencer.
package frogger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_DYING     = 3'd2,
        ST_SCORED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [2:0] TILE_WATER = 3'd2;
    localparam logic [2:0] TILE_LILY  = 3'd4;

    localparam int FROG_ORIGIN_X = 10;
    localparam int FROG_ORIGIN_Y = 14;

    localparam int SCORE_W = 7;

endpackage

// File: rtl/frogger_game_fsm_if.sv
// Game sequencer bus: frame/button/collision inputs and the
// registered game status outputs (state, lives, score, level, etc.).
interface frogger_game_fsm_if;

    logic       i_VSync;
    logic       i_Game_Start;
    logic       i_Collided;
    logic [2:0] i_Bitmap_Data;

    logic [2:0] o_State;
    logic       o_Game_Active;
    logic       o_Freeze;
    logic       o_Frogger_Reset;
    logic       o_Flash;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic [2:0] o_Level;

    modport master (
        output i_VSync, i_Game_Start, i_Collided, i_Bitmap_Data,
        input  o_State, o_Game_Active, o_Freeze, o_Frogger_Reset,
        input  o_Flash, o_Lives, o_Score, o_Level
    );

    modport slave (
        input  i_VSync, i_Game_Start, i_Collided, i_Bitmap_Data,
        output o_State, o_Game_Active, o_Freeze, o_Frogger_Reset,
        output o_Flash, o_Lives, o_Score, o_Level
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Synchronises VSync and the start button (2 flops each) and emits
// a 1-cycle frame tick on VSync fall and a start pulse on button rise.
// Ports: i_Clk, i_Rst_L, i_VSync, i_Start -> o_Frame_Tick, o_Start_Edge.
module frame_tick_gen (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_VSync,
    input  logic i_Start,
    output logic o_Frame_Tick,
    output logic o_Start_Edge
);

    // [0],[1] synchroniser stages, [2] previous synchronised value
    logic [2:0] r_VSync;
    logic [2:0] r_Start;

    // VSync idles high, so it resets high to avoid a false tick
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_VSync <= 3'b111;
            r_Start <= 3'b000;
        end else begin
            r_VSync <= {r_VSync[1:0], i_VSync};
            r_Start <= {r_Start[1:0], i_Start};
        end
    end

    assign o_Frame_Tick = r_VSync[2] & ~r_VSync[1];
    assign o_Start_Edge = r_Start[1] & ~r_Start[2];

endmodule

// File: rtl/frogger_game_fsm.sv
// Frogger game sequencer: phase, lives, score, level, respawn pulse.
// Ports: i_Clk, i_Rst_L, bus (slave) carrying game inputs/outputs.
module frogger_game_fsm
    import frogger_pkg::*;
#(
    parameter int c_LIVES           = 3,
    parameter int c_DEATH_FRAMES    = 60,
    parameter int c_SCORE_FRAMES    = 30,
    parameter int c_GOALS_PER_LEVEL = 5,
    parameter int c_SCORE_MAX       = 99
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    frogger_game_fsm_if.slave  bus
);

    localparam logic [5:0]         c_DEATH_LAST = 6'(c_DEATH_FRAMES - 1);
    localparam logic [5:0]         c_SCORE_LAST = 6'(c_SCORE_FRAMES - 1);
    localparam logic [1:0]         c_LIVES_INIT = 2'(c_LIVES);
    localparam logic [2:0]         c_GOALS      = 3'(c_GOALS_PER_LEVEL);
    localparam logic [SCORE_W-1:0] c_SMAX       = SCORE_W'(c_SCORE_MAX);

    state_t             r_State;
    state_t             w_Next;
    logic               r_Entry;
    logic [5:0]         r_Cnt;
    logic [5:0]         w_Cnt;
    logic [1:0]         r_Lives;
    logic [1:0]         w_Lives;
    logic [SCORE_W-1:0] r_Score;
    logic [SCORE_W-1:0] w_Score;
    logic [2:0]         r_Level;
    logic [2:0]         w_Level;
    logic [2:0]         r_Goals;
    logic [2:0]         w_Goals;
    logic               r_Flash;
    logic               w_Flash;
    logic               r_Frst;
    logic               w_Frst;
    logic               r_Frst_D;
    logic               r_Active;
    logic               r_Freeze;

    logic w_Tick;
    logic w_Start;
    logic w_Mask;
    logic w_Hazard;
    logic w_Goal;
    logic w_Count;

    frame_tick_gen u_tick (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_VSync      (bus.i_VSync),
        .i_Start      (bus.i_Game_Start),
        .o_Frame_Tick (w_Tick),
        .o_Start_Edge (w_Start)
    );

    // Frog position lags the respawn pulse; blind the hazard/goal
    // inputs for the pulse cycle and the one after it.
    assign w_Mask   = r_Frst | r_Frst_D;
    assign w_Hazard = ~w_Mask &
                      (bus.i_Collided | (bus.i_Bitmap_Data == TILE_WATER));
    assign w_Goal   = ~w_Mask & ~w_Hazard &
                      (bus.i_Bitmap_Data == TILE_LILY);

    // A tick landing on the state-entry cycle is not counted
    assign w_Count  = w_Tick & ~r_Entry;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State <= ST_IDLE;
            r_Entry <= 1'b0;
        end else begin
            r_State <= w_Next;
            r_Entry <= (w_Next != r_State);
        end
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_Start)
                    w_Next = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (w_Hazard)
                    w_Next = ST_DYING;
                else if (w_Goal)
                    w_Next = ST_SCORED;
            end
            ST_DYING: begin
                if (w_Count && r_Cnt == c_DEATH_LAST)
                    w_Next = (r_Lives == 2'd0) ? ST_GAME_OVER : ST_PLAYING;
            end
            ST_SCORED: begin
                if (w_Count && r_Cnt == c_SCORE_LAST)
                    w_Next = ST_PLAYING;
            end
            default: w_Next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_Lives = r_Lives;
        w_Score = r_Score;
        w_Level = r_Level;
        w_Goals = r_Goals;
        w_Cnt   = (w_Next != r_State) ? 6'd0 : r_Cnt + {5'd0, w_Count};
        w_Frst  = (w_Next == ST_PLAYING) && (r_State != ST_PLAYING);
        // Flash starts high and flips after every 8 counted ticks
        w_Flash = (w_Next == ST_DYING) && !w_Cnt[3];
        case (r_State)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_Start) begin
                    w_Lives = c_LIVES_INIT;
                    w_Score = '0;
                    w_Level = 3'd0;
                    w_Goals = 3'd0;
                end
            end
            ST_PLAYING: begin
                if (w_Hazard) begin
                    w_Lives = r_Lives - 2'd1;
                end else if (w_Goal) begin
                    if (r_Score < c_SMAX)
                        w_Score = r_Score + 1'b1;
                    w_Goals = r_Goals + 3'd1;
                end
            end
            ST_SCORED: begin
                if (w_Next == ST_PLAYING && r_Goals == c_GOALS) begin
                    w_Goals = 3'd0;
                    if (r_Level != 3'd7)
                        w_Level = r_Level + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Cnt    <= 6'd0;
            r_Lives  <= 2'd0;
            r_Score  <= '0;
            r_Level  <= 3'd0;
            r_Goals  <= 3'd0;
            r_Flash  <= 1'b0;
            r_Frst   <= 1'b0;
            r_Frst_D <= 1'b0;
            r_Active <= 1'b0;
            r_Freeze <= 1'b1;
        end else begin
            r_Cnt    <= w_Cnt;
            r_Lives  <= w_Lives;
            r_Score  <= w_Score;
            r_Level  <= w_Level;
            r_Goals  <= w_Goals;
            r_Flash  <= w_Flash;
            r_Frst   <= w_Frst;
            r_Frst_D <= r_Frst;
            r_Active <= (w_Next == ST_PLAYING);
            r_Freeze <= (w_Next != ST_PLAYING);
        end
    end

    assign bus.o_State         = r_State;
    assign bus.o_Game_Active   = r_Active;
    assign bus.o_Freeze        = r_Freeze;
    assign bus.o_Frogger_Reset = r_Frst;
    assign bus.o_Flash         = r_Flash;
    assign bus.o_Lives         = r_Lives;
    assign bus.o_Score         = r_Score;
    assign bus.o_Level         = r_Level;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Directed testbench for frogger_game_fsm: reset, start, death,
// goal, game over, level/score saturation and respawn masking.
module tb_frogger_game_fsm;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    frogger_game_fsm_if bus ();

    frogger_game_fsm dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_fall();
        bus.i_VSync = 1'b0;
        repeat (3) step();
    endtask

    task automatic tick_rise();
        bus.i_VSync = 1'b1;
        repeat (3) step();
    endtask

    task automatic tick();
        tick_fall();
        tick_rise();
    endtask

    task automatic wait_pulse(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            if (bus.o_Frogger_Reset) seen = 1'b1;
        end
    endtask

    task automatic do_goal();
        bus.i_Bitmap_Data = 3'd4;
        step();
        bus.i_Bitmap_Data = 3'd0;
        repeat (29) tick();
        tick_fall();
        tick_rise();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.o_State !== 3'd0 || bus.o_Lives !== 2'd0 ||
            bus.o_Score !== 7'd0 || bus.o_Level !== 3'd0) begin
            errors++;
            $display("FAIL reset_counts: st=%0d lv=%0d sc=%0d lvl=%0d want 0/0/0/0",
                     bus.o_State, bus.o_Lives, bus.o_Score, bus.o_Level);
        end
        checks++;
        if (bus.o_Freeze !== 1'b1 || bus.o_Game_Active !== 1'b0 ||
            bus.o_Flash !== 1'b0 || bus.o_Frogger_Reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: frz=%b act=%b fl=%b fr=%b want 1/0/0/0",
                     bus.o_Freeze, bus.o_Game_Active, bus.o_Flash,
                     bus.o_Frogger_Reset);
        end
    endtask

    task automatic test_start();
        bit seen;
        int n;
        bus.i_Game_Start = 1'b1;
        wait_pulse(10, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_pulse: got none want 1 pulse within 10 cycles");
        end
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3 ||
            bus.o_Score !== 7'd0 || bus.o_Game_Active !== 1'b1 ||
            bus.o_Freeze !== 1'b0) begin
            errors++;
            $display("FAIL start_state: st=%0d lv=%0d sc=%0d act=%b frz=%b want 1/3/0/1/0",
                     bus.o_State, bus.o_Lives, bus.o_Score,
                     bus.o_Game_Active, bus.o_Freeze);
        end
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.o_Frogger_Reset) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL start_held: got %0d extra pulses want 0", n);
        end
        bus.i_Game_Start = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_death();
        logic ef;
        bus.i_Collided = 1'b1;
        step();
        bus.i_Collided = 1'b0;
        checks++;
        if (bus.o_State !== 3'd2 || bus.o_Lives !== 2'd2 ||
            bus.o_Flash !== 1'b1 || bus.o_Freeze !== 1'b1) begin
            errors++;
            $display("FAIL death_entry: st=%0d lv=%0d fl=%b frz=%b want 2/2/1/1",
                     bus.o_State, bus.o_Lives, bus.o_Flash, bus.o_Freeze);
        end
        for (int k = 1; k < 60; k++) begin
            tick();
            ef = ((k / 8) % 2 == 0);
            checks++;
            if (bus.o_State !== 3'd2 || bus.o_Flash !== ef) begin
                errors++;
                $display("FAIL death_flash tick %0d: st=%0d fl=%b want 2/%b",
                         k, bus.o_State, bus.o_Flash, ef);
            end
        end
        tick_fall();
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Frogger_Reset !== 1'b1 ||
            bus.o_Flash !== 1'b0 || bus.o_Game_Active !== 1'b1) begin
            errors++;
            $display("FAIL death_exit: st=%0d fr=%b fl=%b act=%b want 1/1/0/1",
                     bus.o_State, bus.o_Frogger_Reset, bus.o_Flash,
                     bus.o_Game_Active);
        end
        tick_rise();
    endtask

    task automatic test_coincide();
        bus.i_Bitmap_Data = 3'd4;
        bus.i_Collided    = 1'b1;
        step();
        bus.i_Bitmap_Data = 3'd0;
        bus.i_Collided    = 1'b0;
        checks++;
        if (bus.o_State !== 3'd2 || bus.o_Score !== 7'd0 ||
            bus.o_Lives !== 2'd1) begin
            errors++;
            $display("FAIL coincide: st=%0d sc=%0d lv=%0d want 2/0/1",
                     bus.o_State, bus.o_Score, bus.o_Lives);
        end
        repeat (59) tick();
        tick_fall();
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Frogger_Reset !== 1'b1) begin
            errors++;
            $display("FAIL coincide_exit: st=%0d fr=%b want 1/1",
                     bus.o_State, bus.o_Frogger_Reset);
        end
        tick_rise();
    endtask

    task automatic test_goal();
        bus.i_Bitmap_Data = 3'd4;
        step();
        bus.i_Bitmap_Data = 3'd0;
        checks++;
        if (bus.o_State !== 3'd3 || bus.o_Score !== 7'd1 ||
            bus.o_Freeze !== 1'b1) begin
            errors++;
            $display("FAIL goal_entry: st=%0d sc=%0d frz=%b want 3/1/1",
                     bus.o_State, bus.o_Score, bus.o_Freeze);
        end
        repeat (29) tick();
        checks++;
        if (bus.o_State !== 3'd3) begin
            errors++;
            $display("FAIL goal_hold: st=%0d want 3 after 29 ticks", bus.o_State);
        end
        tick_fall();
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Frogger_Reset !== 1'b1 ||
            bus.o_Level !== 3'd0) begin
            errors++;
            $display("FAIL goal_exit: st=%0d fr=%b lvl=%0d want 1/1/0",
                     bus.o_State, bus.o_Frogger_Reset, bus.o_Level);
        end
        tick_rise();
    endtask

    task automatic test_game_over();
        bit seen;
        bus.i_Bitmap_Data = 3'd2;
        step();
        bus.i_Bitmap_Data = 3'd0;
        checks++;
        if (bus.o_State !== 3'd2 || bus.o_Lives !== 2'd0) begin
            errors++;
            $display("FAIL water_death: st=%0d lv=%0d want 2/0",
                     bus.o_State, bus.o_Lives);
        end
        repeat (59) tick();
        tick_fall();
        checks++;
        if (bus.o_State !== 3'd4 || bus.o_Lives !== 2'd0 ||
            bus.o_Score !== 7'd1 || bus.o_Frogger_Reset !== 1'b0 ||
            bus.o_Freeze !== 1'b1 || bus.o_Flash !== 1'b0) begin
            errors++;
            $display("FAIL game_over: st=%0d lv=%0d sc=%0d fr=%b frz=%b fl=%b want 4/0/1/0/1/0",
                     bus.o_State, bus.o_Lives, bus.o_Score,
                     bus.o_Frogger_Reset, bus.o_Freeze, bus.o_Flash);
        end
        tick_rise();
        bus.i_Game_Start = 1'b1;
        wait_pulse(10, seen);
        checks++;
        if (!seen || bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3 ||
            bus.o_Score !== 7'd0 || bus.o_Level !== 3'd0) begin
            errors++;
            $display("FAIL restart: pulse=%b st=%0d lv=%0d sc=%0d lvl=%0d want 1/1/3/0/0",
                     seen, bus.o_State, bus.o_Lives, bus.o_Score, bus.o_Level);
        end
        bus.i_Game_Start = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_level();
        repeat (4) do_goal();
        checks++;
        if (bus.o_Level !== 3'd0 || bus.o_Score !== 7'd4) begin
            errors++;
            $display("FAIL level_4goals: lvl=%0d sc=%0d want 0/4",
                     bus.o_Level, bus.o_Score);
        end
        do_goal();
        checks++;
        if (bus.o_Level !== 3'd1 || bus.o_Score !== 7'd5) begin
            errors++;
            $display("FAIL level_5goals: lvl=%0d sc=%0d want 1/5",
                     bus.o_Level, bus.o_Score);
        end
    endtask

    task automatic test_saturation();
        repeat (94) do_goal();
        checks++;
        if (bus.o_Score !== 7'd99 || bus.o_Level !== 3'd7) begin
            errors++;
            $display("FAIL sat_99: sc=%0d lvl=%0d want 99/7",
                     bus.o_Score, bus.o_Level);
        end
        do_goal();
        checks++;
        if (bus.o_Score !== 7'd99 || bus.o_Level !== 3'd7 ||
            bus.o_State !== 3'd1) begin
            errors++;
            $display("FAIL sat_100: sc=%0d lvl=%0d st=%0d want 99/7/1",
                     bus.o_Score, bus.o_Level, bus.o_State);
        end
    endtask

    task automatic test_mask();
        bus.i_Bitmap_Data = 3'd4;
        step();
        bus.i_Bitmap_Data = 3'd0;
        repeat (29) tick();
        tick_fall();
        checks++;
        if (bus.o_Frogger_Reset !== 1'b1) begin
            errors++;
            $display("FAIL mask_pulse: fr=%b want 1", bus.o_Frogger_Reset);
        end
        bus.i_Collided = 1'b1;
        step();
        step();
        bus.i_Collided = 1'b0;
        step();
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Lives !== 2'd3) begin
            errors++;
            $display("FAIL mask_ignore: st=%0d lv=%0d want 1/3",
                     bus.o_State, bus.o_Lives);
        end
        tick_rise();
    endtask

    task automatic test_reset_mid();
        int n;
        checks++;
        if (bus.o_State !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset: st=%0d want 1", bus.o_State);
        end
        rst_n = 1'b0;
        #1;
        test_reset();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.o_Frogger_Reset) n++;
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (n != 0 || bus.o_State !== 3'd0 || bus.o_Frogger_Reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pulses=%0d st=%0d want 0/0", n, bus.o_State);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_VSync       = 1'b1;
        bus.i_Game_Start  = 1'b0;
        bus.i_Collided    = 1'b0;
        bus.i_Bitmap_Data = 3'd0;
        repeat (2) step();
        test_reset();
        rst_n = 1'b1;
        repeat (2) step();
        test_reset();
        test_start();
        test_death();
        test_coincide();
        test_goal();
        test_game_over();
        test_level();
        test_saturation();
        test_mask();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
